// File: rtl/secure_write_gate.sv
// rtl/secure_write_gate.sv - privilege/lock gated write path to a sensitive register stage (optional audit counter: SECURE_WRITE_AUDIT_EN)
module secure_write_gate #(
    parameter int          DATA_W     = 32,
    parameter logic [1:0]  MIN_PRIV   = 2'd2,
    parameter logic [31:0] UNLOCK_KEY = 32'hA5C3_0F1E,
    parameter logic        LOCK_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_priv,
    input  logic              lock_set,
    input  logic              unlock_valid,
    input  logic [31:0]       unlock_key,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    output logic              resp_err,
    output logic              locked
`ifdef SECURE_WRITE_AUDIT_EN
    ,
    output logic [7:0]        viol_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic                req_ready_q;
    logic                wr_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          priv_q;
    logic                locked_q;
    logic                locked_d;
    logic                grant;
    logic                deny_evt;

    // Secure requesters always pass; others need the lock open and enough privilege.
    // The lock is read as it stands during CHECK, so a lock change in that cycle
    // only affects the following request.
    assign grant    = (priv_q == 2'd3) || (!locked_q && (priv_q >= MIN_PRIV));
    assign deny_evt = (state_q == CHECK) && !grant;

    // Request FSM with registered outputs; wr_data is forced to zero outside the commit pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            data_q       <= '0;
            priv_q       <= 2'd0;
        end else begin
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        data_q      <= req_data;
                        priv_q      <= req_priv;
                        req_ready_q <= 1'b0;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (grant) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= data_q;
                        state_q   <= COMMIT;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                COMMIT: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    state_q      <= RESP;
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Sticky lock: setting always beats a simultaneous unlock, and only the exact key opens it.
    always_comb begin
        locked_d = locked_q;
        if (lock_set) begin
            locked_d = 1'b1;
        end else if (unlock_valid && (unlock_key == UNLOCK_KEY)) begin
            locked_d = 1'b0;
        end
    end

    // Lock state register, independent of the request FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q <= LOCK_RESET;
        end else begin
            locked_q <= locked_d;
        end
    end

`ifdef SECURE_WRITE_AUDIT_EN
    logic       bad_key;
    logic [1:0] viol_inc;
    logic [8:0] viol_sum;
    logic [7:0] viol_d;
    logic [7:0] viol_q;

    // A denial and a bad key in the same cycle count as two; the counter pins at 8'hFF.
    always_comb begin
        bad_key  = unlock_valid && (unlock_key != UNLOCK_KEY);
        viol_inc = {1'b0, deny_evt} + {1'b0, bad_key};
        viol_sum = {1'b0, viol_q} + {7'd0, viol_inc};
        viol_d   = viol_sum[8] ? 8'hFF : viol_sum[7:0];
    end

    // Violation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_q <= 8'd0;
        end else begin
            viol_q <= viol_d;
        end
    end

    assign viol_count = viol_q;
`endif

    assign req_ready  = req_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_secure_write_gate.sv
// tb/tb_secure_write_gate.sv - self-checking bench for secure_write_gate (audit checks under SECURE_WRITE_AUDIT_EN)
module tb_secure_write_gate;

    localparam logic [31:0] KEY = 32'hA5C3_0F1E;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [1:0]  req_priv;
    logic        lock_set;
    logic        unlock_valid;
    logic [31:0] unlock_key;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        resp_valid;
    logic        resp_err;
    logic        locked;
`ifdef SECURE_WRITE_AUDIT_EN
    logic [7:0]  viol_count;
`endif

    int n_vec;
    int n_err;

    secure_write_gate dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_priv     (req_priv),
        .lock_set     (lock_set),
        .unlock_valid (unlock_valid),
        .unlock_key   (unlock_key),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .locked       (locked)
`ifdef SECURE_WRITE_AUDIT_EN
        ,
        .viol_count   (viol_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0; lock_set = 1'b0; unlock_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request from IDLE; report cycle offsets (relative to accept) of wr_en and resp_valid.
    task automatic run_req(input logic [1:0] priv, input logic [31:0] data,
                           output int wr_cyc, output logic [31:0] wr_dat,
                           output int resp_cyc, output logic err);
        wr_cyc = -1; resp_cyc = -1; wr_dat = 32'h0; err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_priv = priv; req_data = data;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (wr_en && wr_cyc < 0) begin wr_cyc = k; wr_dat = wr_data; end
            if (resp_valid && resp_cyc < 0) begin resp_cyc = k; err = resp_err; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_lock(input logic set, input logic unl, input logic [31:0] key);
        @(negedge clk);
        lock_set = set; unlock_valid = unl; unlock_key = key;
        @(negedge clk);
        lock_set = 1'b0; unlock_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        n_vec++; if (wr_data !== 32'h0) begin n_err++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        n_vec++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp got %b/%b want 0/0", resp_valid, resp_err); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL reset_locked got %b want 1", locked); end
`ifdef SECURE_WRITE_AUDIT_EN
        n_vec++; if (viol_count !== 8'd0) begin n_err++; $display("FAIL reset_viol got %0d want 0", viol_count); end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_locked_deny();
        int wc, rc; logic [31:0] wd; logic er;
        do_reset();
        run_req(2'd2, 32'h1234_5678, wc, wd, rc, er);
        n_vec++; if (rc !== 2) begin n_err++; $display("FAIL deny_resp_cycle got %0d want 2", rc); end
        n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL deny_resp_err got %b want 1", er); end
        n_vec++; if (wc !== -1) begin n_err++; $display("FAIL deny_no_wr got cycle %0d want none", wc); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL deny_back_idle got %b want 1", req_ready); end
`ifdef SECURE_WRITE_AUDIT_EN
        n_vec++; if (viol_count !== 8'd1) begin n_err++; $display("FAIL deny_viol got %0d want 1", viol_count); end
`endif
    endtask

    task automatic test_unlock_grant();
        int wc, rc; logic [31:0] wd; logic er;
        pulse_lock(1'b0, 1'b1, 32'hA5C3_0F1F);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL badkey_locked got %b want 1", locked); end
`ifdef SECURE_WRITE_AUDIT_EN
        n_vec++; if (viol_count !== 8'd2) begin n_err++; $display("FAIL badkey_viol got %0d want 2", viol_count); end
`endif
        pulse_lock(1'b0, 1'b1, KEY);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL unlock_locked got %b want 0", locked); end
        run_req(2'd2, 32'hDEAD_BEEF, wc, wd, rc, er);
        n_vec++; if (wc !== 2) begin n_err++; $display("FAIL grant_wr_cycle got %0d want 2", wc); end
        n_vec++; if (wd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL grant_wr_data got %h want deadbeef", wd); end
        n_vec++; if (rc !== 3 || er !== 1'b0) begin n_err++; $display("FAIL grant_resp got cycle %0d err %b want 3/0", rc, er); end
        n_vec++; if (wr_data !== 32'h0) begin n_err++; $display("FAIL idle_wr_data got %h want 0", wr_data); end
    endtask

    task automatic test_secure_priv();
        int wc, rc; logic [31:0] wd; logic er;
        pulse_lock(1'b1, 1'b0, 32'h0);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL relock got %b want 1", locked); end
        run_req(2'd3, 32'h0000_00FF, wc, wd, rc, er);
        n_vec++; if (wc !== 2 || wd !== 32'h0000_00FF) begin n_err++; $display("FAIL secure_wr got cycle %0d data %h want 2/000000ff", wc, wd); end
        n_vec++; if (rc !== 3 || er !== 1'b0) begin n_err++; $display("FAIL secure_resp got cycle %0d err %b want 3/0", rc, er); end
    endtask

    task automatic test_lock_priority();
        int wc, rc; logic [31:0] wd; logic er;
        pulse_lock(1'b0, 1'b1, KEY);
        pulse_lock(1'b1, 1'b1, KEY);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL set_beats_unlock got %b want 1", locked); end
        run_req(2'd1, 32'h5555_AAAA, wc, wd, rc, er);
        n_vec++; if (er !== 1'b1 || wc !== -1) begin n_err++; $display("FAIL prio_deny got err %b wr %0d want 1/none", er, wc); end
        pulse_lock(1'b0, 1'b1, KEY);
        run_req(2'd1, 32'h5555_AAAA, wc, wd, rc, er);
        n_vec++; if (er !== 1'b1 || rc !== 2) begin n_err++; $display("FAIL below_min got err %b cycle %0d want 1/2", er, rc); end
        run_req(2'd2, 32'h0BAD_F00D, wc, wd, rc, er);
        n_vec++; if (er !== 1'b0 || wd !== 32'h0BAD_F00D) begin n_err++; $display("FAIL at_min got err %b data %h want 0/0badf00d", er, wd); end
    endtask

    task automatic test_lock_in_check();
        // unlocked here; lock is set during CHECK and must not affect this request
        int wc, rc; logic [31:0] wd; logic er;
        @(negedge clk);
        req_valid = 1'b1; req_priv = 2'd2; req_data = 32'h1357_9BDF;
        @(negedge clk);
        req_valid = 1'b0; lock_set = 1'b1;
        @(negedge clk);
        lock_set = 1'b0;
        n_vec++; if (wr_en !== 1'b1 || wr_data !== 32'h1357_9BDF) begin n_err++; $display("FAIL lock_in_check_wr got %b %h want 1 13579bdf", wr_en, wr_data); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_in_check_locked got %b want 1", locked); end
        repeat (3) @(negedge clk);
        run_req(2'd2, 32'h2468_ACE0, wc, wd, rc, er);
        n_vec++; if (er !== 1'b1 || wc !== -1) begin n_err++; $display("FAIL next_req_locked got err %b wr %0d want 1/none", er, wc); end
    endtask

    task automatic test_reset_mid_commit();
        int seen_wr, seen_resp;
        pulse_lock(1'b0, 1'b1, KEY);
        @(negedge clk);
        req_valid = 1'b1; req_priv = 2'd3; req_data = 32'hCAFE_0001;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL pre_reset_commit got %b want 1", wr_en); end
        rst = 1'b1;
        #1;
        n_vec++; if (wr_en !== 1'b0 || wr_data !== 32'h0) begin n_err++; $display("FAIL abort_wr got %b %h want 0 0", wr_en, wr_data); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL abort_locked got %b want 1", locked); end
        @(negedge clk);
        rst = 1'b0;
        seen_wr = 0; seen_resp = 0;
        for (int k = 0; k < 5; k++) begin
            if (wr_en) seen_wr++;
            if (resp_valid) seen_resp++;
            @(negedge clk);
        end
        n_vec++; if (seen_wr !== 0 || seen_resp !== 0) begin n_err++; $display("FAIL abort_quiet got wr %0d resp %0d want 0/0", seen_wr, seen_resp); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", req_ready); end
    endtask

`ifdef SECURE_WRITE_AUDIT_EN
    task automatic test_saturation();
        int wc, rc; logic [31:0] wd; logic er;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            run_req(2'($urandom_range(0, 2)), $urandom, wc, wd, rc, er);
            if (i == 253) begin
                n_vec++; if (viol_count !== 8'd254) begin n_err++; $display("FAIL sat_pre got %0d want 254", viol_count); end
            end
        end
        n_vec++; if (viol_count !== 8'hFF) begin n_err++; $display("FAIL sat_final got %0d want 255", viol_count); end
    endtask
`endif

    // Reference: transaction latency rules + lock/violation rules, tracked by cycle since accept.
    task automatic test_random();
        int          acc;
        int          d;
        int          m_viol;
        logic        m_locked;
        logic [31:0] adata;
        logic [1:0]  apriv;
        logic        agrant;
        logic        e_ready, e_wr, e_resp, e_err;
        logic [31:0] e_wdata;
        int          deny, bad;
        do_reset();
        acc = -1; m_viol = 0; m_locked = 1'b1; agrant = 1'b0; adata = 0; apriv = 0;
        for (int c = 0; c < 800; c++) begin
            d = (acc < 0) ? 0 : c - acc;
            e_ready = (acc < 0);
            if (d == 1) agrant = (apriv == 2'd3) || (!m_locked && apriv >= 2'd2);
            e_wr    = (d == 2) && agrant;
            e_wdata = e_wr ? adata : 32'h0;
            e_resp  = ((d == 2) && !agrant) || (d == 3);
            e_err   = (d == 2) && !agrant;
            n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready, e_ready); end
            n_vec++; if (wr_en !== e_wr || wr_data !== e_wdata) begin n_err++; $display("FAIL rnd_wr c%0d got %b %h want %b %h", c, wr_en, wr_data, e_wr, e_wdata); end
            n_vec++; if (resp_valid !== e_resp || resp_err !== e_err) begin n_err++; $display("FAIL rnd_resp c%0d got %b/%b want %b/%b", c, resp_valid, resp_err, e_resp, e_err); end
            n_vec++; if (locked !== m_locked) begin n_err++; $display("FAIL rnd_locked c%0d got %b want %b", c, locked, m_locked); end
`ifdef SECURE_WRITE_AUDIT_EN
            n_vec++; if (viol_count !== 8'(m_viol)) begin n_err++; $display("FAIL rnd_viol c%0d got %0d want %0d", c, viol_count, m_viol); end
`endif
            req_valid    = ($urandom_range(0, 1) == 1);
            req_priv     = 2'($urandom_range(0, 3));
            req_data     = $urandom;
            lock_set     = ($urandom_range(0, 7) == 0);
            unlock_valid = ($urandom_range(0, 3) == 0);
            unlock_key   = ($urandom_range(0, 1) == 1) ? KEY : (KEY ^ (32'h1 << $urandom_range(0, 31)));
            deny = (d == 1 && !agrant) ? 1 : 0;
            bad  = (unlock_valid && unlock_key != KEY) ? 1 : 0;
            m_viol = m_viol + deny + bad;
            if (m_viol > 255) m_viol = 255;
            if (lock_set) m_locked = 1'b1;
            else if (unlock_valid && unlock_key == KEY) m_locked = 1'b0;
            if (e_ready && req_valid) begin
                acc = c; adata = req_data; apriv = req_priv;
            end else if (e_resp) begin
                acc = -1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; lock_set = 1'b0; unlock_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_data = 32'h0; req_priv = 2'd0;
        lock_set = 1'b0; unlock_valid = 1'b0; unlock_key = 32'h0;
        test_reset();
        test_locked_deny();
        test_unlock_grant();
        test_secure_priv();
        test_lock_priority();
        test_lock_in_check();
        test_reset_mid_commit();
`ifdef SECURE_WRITE_AUDIT_EN
        test_saturation();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/secure_write_gate.md
SECURE_WRITE_GATE -- requirements
Module: secure_write_gate

Interface
REQ-001 Parameter DATA_W, default 32: width of request data and the downstream write data.
REQ-002 Parameter MIN_PRIV, default 2'd2: lowest privilege allowed to write while unlocked.
REQ-003 Parameter UNLOCK_KEY, default 32'hA5C3_0F1E: key that clears the lock.
REQ-004 Parameter LOCK_RESET, default 1'b1: value of the lock after reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset; asynchronous assert, active-high.
REQ-007 req_valid  in  1  write request present.
REQ-008 req_ready  out  1  gate can accept a request.
REQ-009 req_data  in  DATA_W  requested write value.
REQ-010 req_priv  in  2  requester privilege; 3 = secure.
REQ-011 lock_set  in  1  sets the sticky lock.
REQ-012 unlock_valid  in  1  unlock attempt strobe.
REQ-013 unlock_key  in  32  key presented with unlock_valid.
REQ-014 wr_en  out  1  one-cycle write strobe to the downstream sensitive register stage.
REQ-015 wr_data  out  DATA_W  write value, valid while wr_en=1.
REQ-016 resp_valid  out  1  one-cycle completion pulse.
REQ-017 resp_err  out  1  request denied; valid with resp_valid.
REQ-018 locked  out  1  current lock state.
REQ-019 viol_count  out  8  denied-access count; present only under the macro in REQ-034.

Function
REQ-020 FSM states: IDLE, CHECK, COMMIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid&&req_ready, capture req_data and req_priv, go to CHECK.
REQ-022 CHECK, grant when (req_priv==3) or (!locked && req_priv>=MIN_PRIV), using locked as sampled in CHECK: grant -> COMMIT, deny -> RESP with resp_err=1.
REQ-023 COMMIT: wr_en=1 and wr_data=captured data for exactly one cycle, then go to RESP with resp_err=0.
REQ-024 RESP: resp_valid=1 for one cycle, then go to IDLE; latency from accept is 3 cycles (granted) or 2 cycles (denied).
REQ-025 wr_data SHALL be zero whenever wr_en=0 (no leakage of captured data).
REQ-026 lock_set=1 sets locked on the next edge in any state.
REQ-027 unlock_valid with unlock_key==UNLOCK_KEY clears locked; unlock_valid with a wrong key leaves locked unchanged and is a violation.
REQ-028 lock_set and unlock_valid in the same cycle: lock_set wins and locked=1.
REQ-029 Lock changes during CHECK take effect on the next request only.
REQ-030 Back-to-back requests: a new request is accepted no earlier than the IDLE cycle after RESP.

Reset
REQ-031 While rst=1: state=IDLE, req_ready=1, wr_en=0, wr_data=0, resp_valid=0, resp_err=0, locked=LOCK_RESET, viol_count=0.
REQ-032 Reset mid-transaction SHALL abort it with no wr_en pulse and no resp_valid.
REQ-033 Captured data and priv registers SHALL clear to 0 on reset.

Configuration
REQ-034 With SECURE_WRITE_AUDIT_EN defined: viol_count increments by 1 on each denied request and each wrong-key unlock, saturating at 8'hFF; a denial and a bad key in the same cycle add 2, also saturating.
REQ-035 Without SECURE_WRITE_AUDIT_EN: the viol_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-036 Reset, locked=1, req priv=2 data=32'h1234_5678 -> resp_valid at cycle+2 with resp_err=1, wr_en never 1, viol_count=1.
REQ-037 unlock_key=32'hA5C3_0F1E, then req priv=2 data=32'hDEAD_BEEF -> wr_en=1 with wr_data=32'hDEAD_BEEF at cycle+2, resp_valid with err=0 at cycle+3.
REQ-038 Locked, req priv=3 data=32'h0000_00FF -> granted, wr_en pulse, resp_err=0.
REQ-039 lock_set and unlock_valid with the correct key in the same cycle -> locked=1; then unlocked req priv=1 -> resp_err=1.
REQ-040 rst asserted during COMMIT -> wr_en=0 immediately, no resp_valid, locked=LOCK_RESET.
REQ-041 Audit build: 300 denied requests -> viol_count=8'hFF, no wrap.
